// File: rtl/seg7_pkg.sv
// Shared constants, state types and segment decode for the 3-digit scan driver.
package seg7_pkg;

  localparam int unsigned BIN_W    = 10;
  localparam int unsigned BCD_W    = 12;
  localparam int unsigned N_DIGITS = 3;
  localparam int unsigned MAX_VAL  = 999;

  localparam logic [7:0] SEG_0     = 8'hC0;
  localparam logic [7:0] SEG_1     = 8'hF9;
  localparam logic [7:0] SEG_2     = 8'hA4;
  localparam logic [7:0] SEG_3     = 8'hB0;
  localparam logic [7:0] SEG_4     = 8'h99;
  localparam logic [7:0] SEG_5     = 8'h92;
  localparam logic [7:0] SEG_6     = 8'h82;
  localparam logic [7:0] SEG_7     = 8'hF8;
  localparam logic [7:0] SEG_8     = 8'h80;
  localparam logic [7:0] SEG_9     = 8'h90;
  localparam logic [7:0] SEG_BLANK = 8'hFF;

  typedef enum logic {StBlank = 1'b0, StShow = 1'b1} scan_st_e;
  typedef enum logic {StIdle = 1'b0, StShift = 1'b1} conv_st_e;

  // Active-low pattern with dp off; non-decimal nibbles go dark.
  function automatic logic [7:0] seg_decode(input logic [3:0] nib);
    logic [7:0] seg;
    case (nib)
      4'd0:    seg = SEG_0;
      4'd1:    seg = SEG_1;
      4'd2:    seg = SEG_2;
      4'd3:    seg = SEG_3;
      4'd4:    seg = SEG_4;
      4'd5:    seg = SEG_5;
      4'd6:    seg = SEG_6;
      4'd7:    seg = SEG_7;
      4'd8:    seg = SEG_8;
      4'd9:    seg = SEG_9;
      default: seg = SEG_BLANK;
    endcase
    return seg;
  endfunction

endpackage

// File: rtl/seg7_scan_driver_if.sv
// Load/busy handshake between the value producer and the scan driver.
interface seg7_scan_driver_if;
  import seg7_pkg::*;

  logic [BIN_W-1:0] value;
  logic             load;
  logic             busy;
  logic             done;

  modport master (output value, output load, input busy, input done);
  modport slave  (input value, input load, output busy, output done);

endinterface

// File: rtl/bin2bcd_seq.sv
// Sequential shift-add-3 binary-to-BCD converter, one bit per cycle.
module bin2bcd_seq
  import seg7_pkg::*;
(
  input  logic             Clk,
  input  logic             Rst_n,
  input  logic             start_i,
  input  logic [BIN_W-1:0] bin_i,
  output logic             busy_o,
  output logic             done_o,
  output logic             res_valid_o,
  output logic [BCD_W-1:0] res_o
);

  localparam logic [BIN_W-1:0] MAX_BIN = BIN_W'(MAX_VAL);
  localparam logic [3:0]       STEPS   = 4'(BIN_W);

  conv_st_e         state_q, state_d;
  logic [BIN_W-1:0] bin_q, bin_d;
  logic [BCD_W-1:0] bcd_q, bcd_d, bcd_adj;
  logic [3:0]       cnt_q, cnt_d;
  logic             done_q, done_d;

  always_comb begin
    for (int i = 0; i < N_DIGITS; i++) begin
      bcd_adj[4*i +: 4] = (bcd_q[4*i +: 4] >= 4'd5) ? bcd_q[4*i +: 4] + 4'd3
                                                     : bcd_q[4*i +: 4];
    end
  end

  always_comb begin
    state_d     = state_q;
    bin_d       = bin_q;
    bcd_d       = bcd_q;
    cnt_d       = cnt_q;
    done_d      = 1'b0;
    res_valid_o = 1'b0;
    // Result of the current step; on the last step this is the final BCD value.
    res_o       = {bcd_adj[BCD_W-2:0], bin_q[BIN_W-1]};
    case (state_q)
      StIdle: begin
        if (start_i) begin
          bin_d   = (bin_i > MAX_BIN) ? MAX_BIN : bin_i;
          bcd_d   = '0;
          cnt_d   = STEPS;
          state_d = StShift;
        end
      end
      StShift: begin
        bcd_d = res_o;
        bin_d = {bin_q[BIN_W-2:0], 1'b0};
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) begin
          res_valid_o = 1'b1;
          done_d      = 1'b1;
          state_d     = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (!Rst_n) begin
      state_q <= StIdle;
      bin_q   <= '0;
      bcd_q   <= '0;
      cnt_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      bin_q   <= bin_d;
      bcd_q   <= bcd_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
    end
  end

  assign busy_o = (state_q == StShift);
  assign done_o = done_q;

endmodule

// File: rtl/seg7_scan_driver.sv
// 3-digit multiplexed seven-segment driver: scan tick detect, scan FSM,
// display registers and segment decode around the sequential BCD converter.
module seg7_scan_driver
  import seg7_pkg::*;
#(
  parameter bit LZB = 1'b1
) (
  input  logic                Clk,
  input  logic                Rst_n,
  input  logic                scan_clk,
  seg7_scan_driver_if.slave   bus,
  output logic [7:0]          seg_n,
  output logic [N_DIGITS-1:0] digit_en_n
);

  logic                scan_d_q;
  logic                tick;
  scan_st_e            scan_q, scan_d;
  logic [1:0]          idx_q, idx_d;
  logic [BCD_W-1:0]    disp_q, disp_d;
  logic [7:0]          seg_q, seg_d;
  logic [N_DIGITS-1:0] en_q, en_d;
  logic                done_q;
  logic                conv_busy, conv_done, res_valid;
  logic [BCD_W-1:0]    res;
  logic [3:0]          nib;
  logic                blank;

  bin2bcd_seq u_bin2bcd (
    .Clk         (Clk),
    .Rst_n       (Rst_n),
    .start_i     (bus.load),
    .bin_i       (bus.value),
    .busy_o      (conv_busy),
    .done_o      (conv_done),
    .res_valid_o (res_valid),
    .res_o       (res)
  );

  assign tick   = scan_clk & ~scan_d_q;
  assign disp_d = res_valid ? res : disp_q;

  always_comb begin
    nib   = disp_q[3:0];
    blank = 1'b0;
    case (idx_q)
      2'd1: begin
        nib   = disp_q[7:4];
        blank = LZB && (disp_q[11:4] == 8'd0);
      end
      2'd2: begin
        nib   = disp_q[11:8];
        blank = LZB && (disp_q[11:8] == 4'd0);
      end
      default: ;
    endcase
  end

  // Outputs are loaded only on BLANK->SHOW so a digit never changes mid-show.
  always_comb begin
    scan_d = scan_q;
    idx_d  = idx_q;
    seg_d  = seg_q;
    en_d   = en_q;
    if (tick) begin
      scan_d = StBlank;
      seg_d  = SEG_BLANK;
      en_d   = '1;
      idx_d  = (idx_q == 2'd2) ? 2'd0 : idx_q + 2'd1;
    end else if (scan_q == StBlank) begin
      scan_d = StShow;
      seg_d  = blank ? SEG_BLANK : seg_decode(nib);
      en_d   = ~(3'b001 << idx_q);
    end
  end

  always_ff @(posedge Clk) begin
    if (!Rst_n) begin
      scan_d_q <= 1'b0;
      scan_q   <= StShow;
      idx_q    <= 2'd0;
      disp_q   <= '0;
      seg_q    <= SEG_BLANK;
      en_q     <= '1;
      done_q   <= 1'b0;
    end else begin
      scan_d_q <= scan_clk;
      scan_q   <= scan_d;
      idx_q    <= idx_d;
      disp_q   <= disp_d;
      seg_q    <= seg_d;
      en_q     <= en_d;
      done_q   <= conv_done;
    end
  end

  assign bus.busy   = conv_busy;
  assign bus.done   = done_q;
  assign seg_n      = seg_q;
  assign digit_en_n = en_q;

endmodule

// File: doc/seg7_scan_driver.md
# seg7_scan_driver

Drives the board's 3-digit multiplexed seven-segment display from a 10-bit binary value. It sits directly downstream of the clock divider and consumes its slow scan clock output as a digit-advance strobe. Binary-to-BCD conversion is sequential (shift-add-3), so a new value is accepted only via a load/busy handshake, and the displayed digits update atomically.

## Interface
- `LZB`, default 1: leading-zero blanking enable (1 = blank leading zeros of hundreds/tens).
- `Clk`, in, 1: system clock. All logic is on its rising edge.
- `Rst_n`, in, 1: reset. Synchronous and active-low.
- `scan_clk`, in, 1: divided clock level from the clock divider, generated in the `Clk` domain. Only its rising edges are used.
- `value`, in, 10: binary value to display.
- `load`, in, 1: request to capture `value`. Honoured only when `busy`=0.
- `busy`, out, 1: conversion in progress.
- `done`, out, 1: 1-cycle pulse when the display registers update.
- `seg_n`, out, 8: active-low segments, `[7]`=dp, `[6:0]`={g,f,e,d,c,b,a}.
- `digit_en_n`, out, 3: active-low digit enables. `[0]`=ones, `[1]`=tens, `[2]`=hundreds.

## Operation
- **Reset** (`Rst_n`=0 at an edge) sets: `seg_n`=8'hFF, `digit_en_n`=3'b111, `busy`=0, `done`=0, scan index=0, display BCD=0/0/0, `scan_d`=0.
- **Scan tick**
  - `scan_d` registers `scan_clk`.
  - `tick` = `scan_clk & ~scan_d`.
  - `scan_clk` held high or low produces no ticks.
- **Scan FSM**, states BLANK and SHOW.
  - On `tick` from any state: go to BLANK, set `digit_en_n`=111 and `seg_n`=FF, and advance the index 0→1→2→0.
  - BLANK → SHOW next cycle unconditionally. SHOW drives `digit_en_n` with only the indexed bit low and `seg_n` with that digit's pattern.
  - SHOW holds until the next `tick`.
  - After reset the FSM is in SHOW with index 0 and outputs at their reset values. The first tick goes to BLANK with index 1.
- **Conversion FSM**, states IDLE and SHIFT.
  - In IDLE, `load`=1 captures `value`, saturated: values above 999 become 999. The counter is set to 10, `busy`=1, and the FSM goes to SHIFT.
  - In SHIFT, each cycle performs one step: add 3 to each BCD nibble that is ≥5, then shift left by one, bringing in the next binary MSB.
  - On the 10th step, write the 12-bit BCD result to the display registers, clear `busy`, pulse `done` next cycle, and return to IDLE.
  - `load` while `busy`=1 is ignored; nothing is queued.
- **Segment map, active-low with dp off**
  - 0=C0, 1=F9, 2=A4, 3=B0, 4=99, 5=92, 6=82, 7=F8, 8=80, 9=90, blank=FF.
  - BCD nibbles >9 cannot occur. If they did, they map to FF.
- **Leading-zero blanking** (LZB=1):
  - hundreds blanks when it is 0;
  - tens blanks when hundreds and tens are both 0;
  - ones never blanks.
  - LZB=0 shows all digits.
- **Simultaneous events**
  - `tick` and a display-register write in the same cycle: SHOW after BLANK uses the new value.
  - `Rst_n`=0 mid-conversion aborts it. Display registers return to 000.

## Timing
- Load is sampled at edge E0. `busy`=1 after E0. The shift steps occur at E1..E10.
- The display registers and `busy`=0 take effect after E10. `done`=1 for the cycle after E11.
- Load-to-display latency is 10 cycles. The earliest next accepted load is at E11.
- Scan: the edge where `tick`=1 blanks the display. The new digit is driven one cycle later, giving exactly 1 blank cycle per step.
- With the 1201-cycle divider period, each digit is shown for 1200 cycles.
- All outputs are registered. There is no combinational path from inputs to outputs.

## Structure
- **Package `seg7_pkg`:**
  - the 10 segment constants and `SEG_BLANK`=8'hFF;
  - `BIN_W`=10, `BCD_W`=12, `N_DIGITS`=3, `MAX_VAL`=999;
  - scan and conversion state typedefs.
- **Sub-module `bin2bcd_seq`:** conversion FSM plus shift-add-3 datapath with a start/busy/done interface. The top level holds tick detection, the scan FSM, the display registers and the segment decode.

## Test plan
- **Reset:** `Rst_n`=0 for 3 cycles mid-scan → `seg_n`=FF, `digit_en_n`=111, `busy`=0, `done`=0.
- **Normal load:** `load` with `value`=307 → `busy` high exactly 10 cycles, then `done` pulse. Scan then shows hundreds B0, tens C0, ones F8, with one all-FF/111 cycle between digits.
- **Saturation:** `value`=1000, then 1023 → each displays 9/9/9 (`seg_n`=90 on all digits).
- **Leading-zero blanking:**
  - LZB=1, `value`=5 → hundreds and tens FF, ones 92.
  - `value`=40 → hundreds FF, tens 99, ones C0.
  - LZB=0, `value`=5 → C0/C0/92.
- **Handshake:**
  - `load` of 123 at E0, then `load` of 456 at E3 → only 123 is displayed.
  - `scan_clk` held high for 5000 cycles → index does not advance.
- **Reset mid-conversion:** `Rst_n`=0 at E5 → `busy`=0 and the display is 000 (LZB=1: FF/FF/C0). A subsequent load of 999 completes normally.
